// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and helpers for the parametrised UART receiver.
//                Holds the receive FSM state encoding, the parity sense
//                encoding and the tick-counter width helper.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

    // Receive FSM states, 3-bit encoding
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BRK    = 3'd5
    } state_t;

    // Parity sense: the value the XOR of data and parity bit must produce
    typedef enum logic {
        PAR_EVEN = 1'b0,
        PAR_ODD  = 1'b1
    } parity_mode_t;

    // Tick counter is one bit wider than needed to index a bit period
    function automatic int cnt_width(input int oversample);
        return $clog2(oversample) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sampler.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_sampler
//  Description : Input front end of the UART receiver: 2-flop synchroniser,
//                oversampling tick counter and 3-sample majority vote around
//                the middle of each bit period.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic baud_tick,
    input  logic rx,
    input  logic hold,
    output logic rxs,
    output logic bit_val,
    output logic bit_strobe
);

    localparam int              CW     = cnt_width(OVERSAMPLE);
    localparam logic [CW-1:0]   C_MIDM = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0]   C_MID  = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0]   C_MIDP = CW'(OVERSAMPLE / 2 + 1);
    localparam logic [CW-1:0]   C_LAST = CW'(OVERSAMPLE - 1);

    logic          sync1;
    logic [CW-1:0] count;
    logic          samp_a;
    logic          samp_b;

    // Two-flop synchroniser, resets to the idle (high) line level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= rx;
            rxs   <= sync1;
        end
    end

    // Tick counter: held at zero while the FSM idles, wraps once per bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (hold) begin
            count <= '0;
        end else if (baud_tick) begin
            if (count == C_LAST) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

    // Capture the first two vote samples; the third is taken live
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            samp_a <= 1'b0;
            samp_b <= 1'b0;
        end else if (baud_tick && !hold) begin
            if (count == C_MIDM) begin
                samp_a <= rxs;
            end
            if (count == C_MID) begin
                samp_b <= rxs;
            end
        end
    end

    // Vote resolves on the tick after the centre sample
    assign bit_strobe = baud_tick && !hold && (count == C_MIDP);
    assign bit_val    = (samp_a & samp_b) | (samp_a & rxs) | (samp_b & rxs);

endmodule
`default_nettype wire

// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_param
//  Description : Parametrised UART receiver. Frame FSM, LSB-first shift
//                register, parity/framing/break detection and a single-entry
//                ready/valid holding register with overrun reporting.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud_tick,
    input  logic                 rx,
    input  logic                 rx_ready,
    output logic                 rx_valid,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 break_det,
    output logic                 overrun_err
);

    localparam int            CW        = cnt_width(OVERSAMPLE);
    localparam logic [CW-1:0] BRK_LAST  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
    localparam parity_mode_t  PAR_MODE  = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;
    localparam logic          PAR_SENSE = (PAR_MODE == PAR_ODD);
    localparam logic          PAR_ON    = (PARITY_EN != 0);

    state_t               state;
    state_t               state_nxt;
    logic                 rxs;
    logic                 bit_val;
    logic                 bit_strobe;
    logic                 sampler_hold;
    logic [DATA_BITS-1:0] shreg;
    logic [3:0]           bit_idx;
    logic                 par_bit;
    logic                 par_err_int;
    logic                 frm_err_int;
    logic [CW-1:0]        brk_cnt;
    logic                 frame_done;
    logic                 frm_err_fin;
    logic                 brk_fin;

    // Counter only runs while a frame is in flight
    assign sampler_hold = (state == IDLE) || (state == BRK);

    uart_rx_sampler #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_sampler (
        .clk        (clk),
        .reset      (reset),
        .baud_tick  (baud_tick),
        .rx         (rx),
        .hold       (sampler_hold),
        .rxs        (rxs),
        .bit_val    (bit_val),
        .bit_strobe (bit_strobe)
    );

    // Final stop vote: the frame completes and its flags are resolved here
    assign frame_done  = (state == STOP) && bit_strobe && (bit_idx == STOP_LAST);
    assign frm_err_fin = frm_err_int | ~bit_val;
    assign brk_fin     = (shreg == '0) && (!PAR_ON || !par_bit) && frm_err_fin;

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!rxs) begin
                    state_nxt = START;
                end
            end
            START: begin
                if (bit_strobe) begin
                    state_nxt = bit_val ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_strobe && (bit_idx == DATA_LAST)) begin
                    state_nxt = PAR_ON ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (bit_strobe) begin
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (frame_done) begin
                    state_nxt = brk_fin ? BRK : IDLE;
                end
            end
            BRK: begin
                if (baud_tick && rxs && (brk_cnt == BRK_LAST)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Bit index, shift register and per-frame error accumulation
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg       <= '0;
            bit_idx     <= '0;
            par_bit     <= 1'b0;
            par_err_int <= 1'b0;
            frm_err_int <= 1'b0;
        end else begin
            if (state != state_nxt) begin
                bit_idx <= '0;
            end else if (bit_strobe) begin
                bit_idx <= bit_idx + 4'd1;
            end

            if (state == IDLE) begin
                par_bit     <= 1'b0;
                par_err_int <= 1'b0;
                frm_err_int <= 1'b0;
            end

            if (bit_strobe) begin
                case (state)
                    DATA: shreg <= {bit_val, shreg[DATA_BITS-1:1]};
                    PARITY: begin
                        par_bit     <= bit_val;
                        par_err_int <= (^shreg) ^ bit_val ^ PAR_SENSE;
                    end
                    STOP: begin
                        if (!bit_val) begin
                            frm_err_int <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Break exit: count consecutive high ticks, restart on any low tick
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            brk_cnt <= '0;
        end else if (state != BRK) begin
            brk_cnt <= '0;
        end else if (baud_tick) begin
            brk_cnt <= rxs ? brk_cnt + 1'b1 : '0;
        end
    end

    // Holding register: load on completion if free or being read, else drop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_valid    <= 1'b0;
            rx_data     <= '0;
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            break_det   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            overrun_err <= 1'b0;
            if (frame_done) begin
                if (!rx_valid || rx_ready) begin
                    rx_valid   <= 1'b1;
                    rx_data    <= shreg;
                    frame_err  <= frm_err_fin;
                    parity_err <= par_err_int;
                    break_det  <= brk_fin;
                end else begin
                    overrun_err <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_param
//  Description : Self-checking bench for uart_rx_param. Two instances: the
//                default 8N1 receiver and an 8E2 receiver. Frames are driven
//                bit by bit on the tick grid; expected words are queued when
//                a frame is issued and popped by per-instance monitors.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_rx_param;

    localparam int OS       = 16;
    localparam int TICK_DIV = 4;

    typedef struct {
        logic [7:0] data;
        logic       fe;
        logic       pe;
        logic       bd;
    } exp_t;

    logic       clk       = 1'b0;
    logic       reset     = 1'b1;
    logic       baud_tick = 1'b0;
    logic       rx_d      = 1'b1;
    logic       rx_p      = 1'b1;
    logic       rx_ready  = 1'b1;

    logic       valid_d, fe_d, pe_d, bd_d, ov_d;
    logic [7:0] data_d;
    logic       valid_p, fe_p, pe_p, bd_p, ov_p;
    logic [7:0] data_p;

    exp_t q_d[$];
    exp_t q_p[$];
    exp_t brk_e;
    int   checks    = 0;
    int   failures  = 0;
    int   ov_cnt_d  = 0;
    int   ov_cnt_p  = 0;
    int   nwords_d  = 0;
    int   nwords_p  = 0;
    int   w0;
    bit   ready_rand = 1'b0;
    bit   ready_val  = 1'b1;

    uart_rx_param dut_d (
        .clk         (clk),
        .reset       (reset),
        .baud_tick   (baud_tick),
        .rx          (rx_d),
        .rx_ready    (rx_ready),
        .rx_valid    (valid_d),
        .rx_data     (data_d),
        .frame_err   (fe_d),
        .parity_err  (pe_d),
        .break_det   (bd_d),
        .overrun_err (ov_d)
    );

    uart_rx_param #(
        .DATA_BITS  (8),
        .OVERSAMPLE (OS),
        .PARITY_EN  (1),
        .PARITY_ODD (0),
        .STOP_BITS  (2)
    ) dut_p (
        .clk         (clk),
        .reset       (reset),
        .baud_tick   (baud_tick),
        .rx          (rx_p),
        .rx_ready    (rx_ready),
        .rx_valid    (valid_p),
        .rx_data     (data_p),
        .frame_err   (fe_p),
        .parity_err  (pe_p),
        .break_det   (bd_p),
        .overrun_err (ov_p)
    );

    always #5 clk = ~clk;

    // One-clk baud_tick every TICK_DIV clocks
    initial begin
        forever begin
            repeat (TICK_DIV - 1) @(posedge clk);
            #1 baud_tick = 1'b1;
            @(posedge clk);
            #1 baud_tick = 1'b0;
        end
    end

    // Consumer: fixed or randomly stalling
    initial begin
        forever begin
            @(posedge clk);
            #1 rx_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_val;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic check_word(input bit sel, input logic [7:0] d, input logic fe,
                              input logic pe, input logic bd);
        exp_t e;
        checks++;
        if ((sel && q_p.size() == 0) || (!sel && q_d.size() == 0)) begin
            failures++;
            $display("FAIL %s unexpected_word actual=0x%0h required=none",
                     sel ? "p" : "d", d);
        end else begin
            if (sel) e = q_p.pop_front();
            else     e = q_d.pop_front();
            chk(sel ? "p_data" : "d_data", 32'(d),  32'(e.data));
            chk(sel ? "p_fe"   : "d_fe",   32'(fe), 32'(e.fe));
            chk(sel ? "p_pe"   : "d_pe",   32'(pe), 32'(e.pe));
            chk(sel ? "p_bd"   : "d_bd",   32'(bd), 32'(e.bd));
        end
    endtask

    // Monitors: a word is consumed on every clk with valid && ready
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (ov_d) ov_cnt_d++;
                if (valid_d && rx_ready) begin
                    nwords_d++;
                    check_word(1'b0, data_d, fe_d, pe_d, bd_d);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (ov_p) ov_cnt_p++;
                if (valid_p && rx_ready) begin
                    nwords_p++;
                    check_word(1'b1, data_p, fe_p, pe_p, bd_p);
                end
            end
        end
    end

    task automatic tick_wait(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!baud_tick) @(posedge clk);
        end
    endtask

    // Drive a line level for n tick intervals, starting just after a tick
    task automatic hold_line(input bit sel, input bit v, input int n);
        #1;
        if (sel) rx_p = v;
        else     rx_d = v;
        tick_wait(n);
    endtask

    // Issue one frame; the expected word comes from the frame's own rules
    task automatic send_frame(input bit sel, input logic [7:0] data, input bit pbit,
                              input bit stopv, input int gbit, input bit expect_word);
        exp_t e;
        int   nstop;
        nstop  = sel ? 2 : 1;
        e.data = data;
        e.fe   = !stopv;
        e.pe   = sel && ((($countones(data) + int'(pbit)) % 2) != 0);
        e.bd   = (data == 8'h00) && (!sel || !pbit) && !stopv;
        if (expect_word) begin
            if (sel) q_p.push_back(e);
            else     q_d.push_back(e);
        end
        hold_line(sel, 1'b0, OS);
        for (int b = 0; b < 8; b++) begin
            if (b == gbit) begin
                hold_line(sel, data[b], OS / 2);
                hold_line(sel, ~data[b], 1);
                hold_line(sel, data[b], OS / 2 - 1);
            end else begin
                hold_line(sel, data[b], OS);
            end
        end
        if (sel) hold_line(sel, pbit, OS);
        for (int s = 0; s < nstop; s++) hold_line(sel, stopv, OS);
        hold_line(sel, 1'b1, int'($urandom_range(20, 40)));
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && (q_d.size() != 0 || q_p.size() != 0); i++) begin
            @(posedge clk);
        end
        chk("drain_d", q_d.size(), 0);
        chk("drain_p", q_p.size(), 0);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_valid_d"}, 32'(valid_d), 0);
        chk({tag, "_data_d"},  32'(data_d),  0);
        chk({tag, "_flags_d"}, 32'({fe_d, pe_d, bd_d, ov_d}), 0);
        chk({tag, "_valid_p"}, 32'(valid_p), 0);
        chk({tag, "_flags_p"}, 32'({fe_p, pe_p, bd_p, ov_p}), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 chk_zero_outputs("reset");
        reset = 1'b0;
        tick_wait(2);

        // Clean 8N1 word
        send_frame(1'b0, 8'hA5, 1'b0, 1'b1, -1, 1'b1);

        // Even parity: wrong then correct parity bit
        send_frame(1'b1, 8'h03, 1'b1, 1'b1, -1, 1'b1);
        send_frame(1'b1, 8'h03, 1'b0, 1'b1, -1, 1'b1);
        drain();

        // False start: 5-tick low glitch yields nothing
        w0 = nwords_d;
        hold_line(1'b0, 1'b0, 5);
        hold_line(1'b0, 1'b1, 40);
        chk("false_start_no_word", nwords_d, w0);

        // Single-tick inversion at a bit centre is outvoted
        send_frame(1'b0, 8'h5A, 1'b0, 1'b1, 3, 1'b1);

        // Low stop bit, then a clean frame
        send_frame(1'b0, 8'h7E, 1'b0, 1'b0, -1, 1'b1);
        send_frame(1'b0, 8'h11, 1'b0, 1'b1, -1, 1'b1);

        // Break: line low for three frame times gives exactly one word
        brk_e.data = 8'h00;
        brk_e.fe   = 1'b1;
        brk_e.pe   = 1'b0;
        brk_e.bd   = 1'b1;
        q_d.push_back(brk_e);
        hold_line(1'b0, 1'b0, 3 * 10 * OS);
        hold_line(1'b0, 1'b1, 40);
        send_frame(1'b0, 8'h42, 1'b0, 1'b1, -1, 1'b1);
        drain();

        // Overrun: consumer stalled, second frame dropped
        ready_val = 1'b0;
        tick_wait(1);
        send_frame(1'b0, 8'h12, 1'b0, 1'b1, -1, 1'b1);
        send_frame(1'b0, 8'h34, 1'b0, 1'b1, -1, 1'b0);
        @(negedge clk);
        chk("ovr_valid", 32'(valid_d), 1);
        chk("ovr_hold_data", 32'(data_d), 32'h12);
        chk("ovr_pulses", ov_cnt_d, 1);
        ready_val = 1'b1;
        drain();

        // Reset mid-frame of 0x56: outputs clear at once, nothing delivered
        tick_wait(1);
        w0 = nwords_d;
        hold_line(1'b0, 1'b0, OS);
        hold_line(1'b0, 1'b0, OS);
        hold_line(1'b0, 1'b1, OS);
        hold_line(1'b0, 1'b1, OS);
        #1;
        rx_d  = 1'b1;
        reset = 1'b1;
        #1 chk_zero_outputs("midrst");
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        tick_wait(200);
        chk("midrst_no_word", nwords_d, w0);

        // Randomised frames on both receivers with a stalling consumer
        ready_rand = 1'b1;
        for (int n = 0; n < 24; n++) begin
            bit         sel;
            logic [7:0] d;
            bit         pb;
            bit         sv;
            int         gb;
            sel = 1'($urandom_range(0, 1));
            d   = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            pb  = 1'($urandom_range(0, 1));
            sv  = ($urandom_range(0, 3) != 0);
            gb  = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 7)) : -1;
            send_frame(sel, d, pb, sv, gb, 1'b1);
        end
        drain();
        ready_rand = 1'b0;

        chk("ovr_total_d", ov_cnt_d, 1);
        chk("ovr_total_p", ov_cnt_p, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver, next generation of the fixed 8N1 receiver used on the host link of the flow-control FPGA.
- Configurable data width, oversampling ratio, parity and stop-bit count.
- 3-sample majority vote per bit, 2-flop input synchroniser, false-start rejection, break detection.
- Buffered ready/valid output with framing, parity and overrun flags. Feeds the command parser.

Parameters:
DATA_BITS, 8, data bits per frame, legal 5..9, LSB first.
OVERSAMPLE, 16, baud_tick pulses per bit period, power of two, >=8.
PARITY_EN, 0, 1 = a parity bit follows the data bits.
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
STOP_BITS, 1, stop bits checked, 1 or 2.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
baud_tick  input  1  one-clk pulse at OVERSAMPLE x baud rate
rx  input  1  asynchronous serial line, idle high
rx_ready  input  1  consumer accepts word when high with rx_valid
rx_valid  output  1  holding register contains an unread word
rx_data  output  DATA_BITS  received word, stable while rx_valid
frame_err  output  1  stop bit sampled low, qualifies rx_data
parity_err  output  1  parity mismatch, qualifies rx_data; 0 when PARITY_EN=0
break_det  output  1  break frame, qualifies rx_data
overrun_err  output  1  one-clk pulse when a completed frame is dropped

Behaviour:
- Reset (async, active-high) forces:
  - state IDLE, all counters 0, synchroniser flops 1.
  - rx_valid=0, rx_data=0, all error flags 0, overrun_err=0.
  - Reset mid-frame abandons the frame; nothing is delivered.
- Synchroniser: rx passes through 2 flops; all FSM decisions use the synced value rxs.
- Tick counter: width $clog2(OVERSAMPLE)+1. It advances only on baud_tick. MID = OVERSAMPLE/2.
- Majority vote: samples rxs on the ticks where count = MID-1, MID and MID+1. Bit value = majority of the 3 samples, resolved at count = MID+1.
- IDLE: rxs=0 -> START, counter cleared.
- START: at the vote point:
  - vote=1 -> false start, back to IDLE, no flags.
  - vote=0 -> DATA with bit index 0.
- Bit timing: the counter wraps at OVERSAMPLE-1, so each later vote falls mid-bit.
- DATA: shift the vote in LSB first. After DATA_BITS votes -> PARITY if PARITY_EN, else STOP.
- PARITY: parity_err_int = XOR(data bits, parity bit, PARITY_ODD) != 0.
- STOP: one vote per stop bit. Any stop vote 0 sets frame_err_int. After the last stop vote:
  - Frame complete on that clk.
  - If data=0 and parity bit=0 (when enabled) and frame_err_int=1 -> break_int, FSM goes to BRK.
  - Otherwise FSM goes to IDLE, without waiting out the rest of the stop bit, for resync margin.
- BRK: stays until rxs=1 for MID consecutive ticks, then IDLE. No start detection while in BRK.
- Completion and holding register:
  - On the completion clk, if holding is free, or freed on that same clk by rx_ready&&rx_valid: load rx_data and the three flags, set rx_valid next clk.
  - Latency: rx_valid rises 1 clk after the final stop-vote tick, which is 2 clk + vote delay after the line edge.
  - If holding is occupied and not being read: drop the new frame, leave holding untouched, pulse overrun_err for 1 clk.
- Handshake:
  - rx_valid&&rx_ready with no completion on that clk -> rx_valid=0 next clk.
  - rx_data and the flags hold their values after the read; they are only meaningful while rx_valid=1.
  - rx_ready is ignored while rx_valid=0.
- A baud_tick arriving on the same clk as a state change is consumed by the new state's counter reset; it is not counted.

Decomposition:
- Shared package uart_pkg:
  - state localparams IDLE, START, DATA, PARITY, STOP, BRK (3-bit encoding).
  - function for counter-width computation.
  - parity-mode constants.
- Sub-module uart_rx_sampler holds the 2-flop synchroniser, tick counter and 3-sample majority vote. It outputs rxs, bit_val and bit_strobe.
- The top level holds the FSM, shift register, error logic and holding register.

Test Plan:
- Defaults (8N1, OVERSAMPLE 16): send 0xA5, rx_ready=1 -> rx_valid for 1 clk, rx_data=0xA5, all flags 0.
- PARITY_EN=1, PARITY_ODD=0: send 0x03 with parity bit 1 -> rx_data=0x03, parity_err=1. Resend with parity bit 0 -> parity_err=0.
- Glitch rx low for 5 ticks, then high -> no rx_valid, FSM back in IDLE. Single-tick inversion inside a mid-bit window of 0x5A -> still 0x5A.
- Stop bit driven low, data 0x7E -> rx_valid, frame_err=1, break_det=0. Following frame 0x11 received cleanly.
- Line held low for 3 frame times, then released -> exactly one word: rx_data=0x00, frame_err=1, break_det=1. Next frame 0x42 is received correctly.
- rx_ready=0, send 0x12 then 0x34 -> overrun_err pulses once, rx_data stays 0x12. Assert reset mid-0x56 frame -> outputs zero, no word delivered.
